// File: rtl/sram_ctrl_wide.sv
// Avalon-MM slave splitting LANES x 16-bit host words into sequential beats on an async 16-bit SRAM.
// Optional SRAM_CTRL_WIDE_STATS_EN adds saturating read/write counters; waitrequest is low only in IDLE.
`timescale 1ns/1ps
module sram_ctrl_wide #(
    parameter int LANES   = 2,
    parameter int SRAM_AW = 20,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 0,
    localparam int HAW    = SRAM_AW - LW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [HAW-1:0]       address,
    input  logic [2*LANES-1:0]   byteenable,
    input  logic                 read,
    input  logic                 write,
    input  logic [16*LANES-1:0]  writedata,
    output logic                 waitrequest,
    output logic [16*LANES-1:0]  readdata,
    output logic                 readdatavalid,
    inout  wire  [15:0]          SRAM_DQ,
    output logic [SRAM_AW-1:0]   SRAM_ADDR,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
`ifdef SRAM_CTRL_WIDE_STATS_EN
    output logic [31:0]          stat_rd_count,
    output logic [31:0]          stat_wr_count,
`endif
    output logic                 SRAM_WE_N
);
    localparam int LCW = (LANES > 1) ? LW : 1;

    typedef enum logic [1:0] {IDLE, RD_BEAT, WR_PULSE, WR_HOLD} state_t;

    state_t               state, state_n;
    logic [LCW-1:0]       lane, lane_n;
    logic [2:0]           wcnt, wcnt_n;
    logic [HAW-1:0]       addr_q;
    logic [2*LANES-1:0]   be_q;
    logic [16*LANES-1:0]  wdata_q, rdata_q;
    logic                 rdv_q, rdv_n, capture, accept;
    logic                 first_found, next_found, dq_oe;
    logic [LCW-1:0]       first_lane, next_lane;
    logic [1:0]           lane_be;
    logic [15:0]          wr_word;

    // Lowest lane >= start whose byte mask is non-zero; lanes with be=00 are skipped entirely.
    function automatic logic [LCW:0] find_lane(input logic [2*LANES-1:0] be, input int start);
        logic [LCW:0] r;
        r = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (k >= start && be[2*k +: 2] != 2'b00) r = {1'b1, LCW'(k)};
        end
        return r;
    endfunction

    assign waitrequest   = reset || (state != IDLE);
    assign accept        = (read || write) && !waitrequest;
    assign readdata      = rdata_q;
    assign readdatavalid = rdv_q;
    assign lane_be       = be_q[2*int'(lane) +: 2];
    assign wr_word       = wdata_q[16*int'(lane) +: 16];
    assign SRAM_DQ       = dq_oe ? wr_word : 16'hzzzz;

    always_comb begin
        {first_found, first_lane} = find_lane(byteenable, 0);
        {next_found, next_lane}   = find_lane(be_q, int'(lane) + 1);
    end

    always_comb begin
        state_n = state;
        lane_n  = lane;
        wcnt_n  = wcnt;
        rdv_n   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    wcnt_n = '0;
                    if (write) begin
                        if (first_found) begin
                            state_n = WR_PULSE;
                            lane_n  = first_lane;
                        end
                    end else begin
                        state_n = RD_BEAT;
                        lane_n  = '0;
                    end
                end
            end
            RD_BEAT: begin
                if (wcnt == 3'(RD_WAIT)) begin
                    capture = 1'b1;
                    wcnt_n  = '0;
                    if (lane == LCW'(LANES - 1)) begin
                        state_n = IDLE;
                        lane_n  = '0;
                        rdv_n   = 1'b1;
                    end else begin
                        lane_n = lane + LCW'(1);
                    end
                end else begin
                    wcnt_n = wcnt + 3'd1;
                end
            end
            WR_PULSE: begin
                if (wcnt == 3'(WR_WAIT)) begin
                    state_n = WR_HOLD;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + 3'd1;
                end
            end
            WR_HOLD: begin
                if (next_found) begin
                    state_n = WR_PULSE;
                    lane_n  = next_lane;
                end else begin
                    state_n = IDLE;
                    lane_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_LB_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_ADDR = '0;
        dq_oe     = 1'b0;
        case (state)
            RD_BEAT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                SRAM_LB_N = 1'b0;
                SRAM_UB_N = 1'b0;
                SRAM_ADDR = (SRAM_AW'(addr_q) << LW) | SRAM_AW'(lane);
            end
            WR_PULSE, WR_HOLD: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = (state == WR_HOLD);
                SRAM_LB_N = ~lane_be[0];
                SRAM_UB_N = ~lane_be[1];
                SRAM_ADDR = (SRAM_AW'(addr_q) << LW) | SRAM_AW'(lane);
                dq_oe     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lane    <= '0;
            wcnt    <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
            wcnt  <= wcnt_n;
            rdv_q <= rdv_n;
            if (accept) begin
                addr_q  <= address;
                be_q    <= byteenable;
                wdata_q <= writedata;
            end
            if (capture) rdata_q[16*int'(lane) +: 16] <= SRAM_DQ;
        end
    end

`ifdef SRAM_CTRL_WIDE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rd_count <= '0;
            stat_wr_count <= '0;
        end else begin
            if (rdv_q && stat_rd_count != 32'hFFFF_FFFF) stat_rd_count <= stat_rd_count + 32'd1;
            if (accept && write && stat_wr_count != 32'hFFFF_FFFF) stat_wr_count <= stat_wr_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_ctrl_wide.sv
// Randomized bench for sram_ctrl_wide with a behavioural SRAM and a word-level reference memory.
`timescale 1ns/1ps
module tb_sram_ctrl_wide;
    localparam int LANES   = 2;
    localparam int SRAM_AW = 20;
    localparam int RD_WAIT = 1;
    localparam int WR_WAIT = 1;
    localparam int HAW     = SRAM_AW - 1;
    localparam int RD_LAT  = 1 + LANES * (RD_WAIT + 1);

    logic                clk = 1'b0;
    logic                reset, read, write;
    logic [HAW-1:0]      address;
    logic [2*LANES-1:0]  byteenable;
    logic [16*LANES-1:0] writedata;
    logic                waitrequest, readdatavalid;
    logic [16*LANES-1:0] readdata;
    wire  [15:0]         SRAM_DQ;
    logic [SRAM_AW-1:0]  SRAM_ADDR;
    logic                SRAM_LB_N, SRAM_UB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
`ifdef SRAM_CTRL_WIDE_STATS_EN
    logic [31:0]         stat_rd_count, stat_wr_count;
`endif

    sram_ctrl_wide #(.LANES(LANES), .SRAM_AW(SRAM_AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .read(read), .write(write), .writedata(writedata), .waitrequest(waitrequest),
        .readdata(readdata), .readdatavalid(readdatavalid), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
`ifdef SRAM_CTRL_WIDE_STATS_EN
        .stat_rd_count(stat_rd_count), .stat_wr_count(stat_wr_count),
`endif
        .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural asynchronous SRAM (low 1K words).
    logic [15:0] sram    [0:1023];
    logic [15:0] ref_mem [0:1023];
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR[9:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (!SRAM_CE_N && !SRAM_WE_N) begin
            if (!SRAM_LB_N) sram[SRAM_ADDR[9:0]][7:0]  <= SRAM_DQ[7:0];
            if (!SRAM_UB_N) sram[SRAM_ADDR[9:0]][15:8] <= SRAM_DQ[15:8];
        end
    end

    int checks = 0;
    int passes = 0;
    int acc_cyc, rdv_cyc, busy, ce_cyc, we_cyc, oe_cyc, lb_cyc, ub_cyc, rdv_cnt;
    logic [16*LANES-1:0] rdv_data;
    logic [SRAM_AW-1:0]  ce_addrs[$];

    function automatic int word_idx(input logic [HAW-1:0] a, input int k);
        return (int'(a) * LANES + k) & 1023;
    endfunction

    function automatic logic [16*LANES-1:0] ref_read(input logic [HAW-1:0] a);
        logic [16*LANES-1:0] r;
        for (int k = 0; k < LANES; k++) r[16*k +: 16] = ref_mem[word_idx(a, k)];
        return r;
    endfunction

    function automatic int active_lanes(input logic [2*LANES-1:0] be);
        int n = 0;
        for (int k = 0; k < LANES; k++) if (be[2*k +: 2] != 2'b00) n++;
        return n;
    endfunction

    task automatic ref_write(input logic [HAW-1:0] a, input logic [2*LANES-1:0] be, input logic [16*LANES-1:0] d);
        for (int k = 0; k < LANES; k++) begin
            if (be[2*k])   ref_mem[word_idx(a, k)][7:0]  = d[16*k +: 8];
            if (be[2*k+1]) ref_mem[word_idx(a, k)][15:8] = d[16*k+8 +: 8];
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Issue one command, wait for acceptance, then record SRAM pin activity until the controller idles.
    task automatic run_cmd(input logic is_wr, input logic both, input logic [HAW-1:0] a,
                           input logic [2*LANES-1:0] be, input logic [16*LANES-1:0] d);
        int n;
        bit done;
        busy = 0; ce_cyc = 0; we_cyc = 0; oe_cyc = 0; lb_cyc = 0; ub_cyc = 0;
        rdv_cnt = 0; rdv_cyc = -1; rdv_data = '0; ce_addrs.delete();
        @(negedge clk);
        address = a; byteenable = be; writedata = d; write = is_wr; read = !is_wr || both;
        n = 0;
        while (waitrequest && n < 50) begin @(negedge clk); n++; end
        acc_cyc = cyc;
        @(posedge clk); #1 read = 1'b0; write = 1'b0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) busy++;
            if (!SRAM_CE_N) ce_addrs.push_back(SRAM_ADDR);
            if (!SRAM_CE_N) ce_cyc++;
            if (!SRAM_WE_N) we_cyc++;
            if (!SRAM_OE_N) oe_cyc++;
            if (!SRAM_WE_N && !SRAM_LB_N) lb_cyc++;
            if (!SRAM_WE_N && !SRAM_UB_N) ub_cyc++;
            if (readdatavalid) begin rdv_cnt++; rdv_cyc = cyc; rdv_data = readdata; end
            if (!waitrequest && (is_wr || rdv_cnt > 0)) done = 1;
        end
        checks++;
        if (!done || n >= 50) $display("FAIL cmd_timeout: done=%0d wait_loops=%0d required done=1 within bound", done, n);
        else passes++;
        if (is_wr) ref_write(a, be, d);
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
        repeat (2) @(negedge clk);
        checks++; if (waitrequest !== 1'b1) $display("FAIL reset_waitrequest: got %b required 1", waitrequest); else passes++;
        checks++; if (readdatavalid !== 1'b0) $display("FAIL reset_rdv: got %b required 0", readdatavalid); else passes++;
        checks++; if (readdata !== '0) $display("FAIL reset_readdata: got %h required 0", readdata); else passes++;
        checks++;
        if ({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N} !== 5'b11111)
            $display("FAIL reset_ctrl: got %b required 11111", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N});
        else passes++;
        checks++; if (SRAM_ADDR !== '0) $display("FAIL reset_addr: got %h required 0", SRAM_ADDR); else passes++;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (waitrequest !== 1'b0) $display("FAIL post_reset_waitrequest: got %b required 0", waitrequest); else passes++;
    endtask

    task automatic test_write_full();
        run_cmd(1'b1, 1'b0, 19'h00010, 4'b1111, 32'hDEADBEEF);
        checks++; if (sram[20'h20] !== 16'hBEEF) $display("FAIL wr_full_lane0: got %h required BEEF", sram[20'h20]); else passes++;
        checks++; if (sram[20'h21] !== 16'hDEAD) $display("FAIL wr_full_lane1: got %h required DEAD", sram[20'h21]); else passes++;
        checks++; if (busy !== 2 * (WR_WAIT + 2)) $display("FAIL wr_full_busy: got %0d required %0d", busy, 2 * (WR_WAIT + 2)); else passes++;
        checks++; if (we_cyc !== 2 * (WR_WAIT + 1)) $display("FAIL wr_full_we: got %0d required %0d", we_cyc, 2 * (WR_WAIT + 1)); else passes++;
        checks++;
        if (ce_addrs.size() != 6 || ce_addrs[0] !== 20'h20 || ce_addrs[5] !== 20'h21)
            $display("FAIL wr_full_order: got %0d beats first=%h last=%h required 6 beats 00020..00021",
                     ce_addrs.size(), (ce_addrs.size() > 0) ? ce_addrs[0] : '0, (ce_addrs.size() > 5) ? ce_addrs[5] : '0);
        else passes++;
    endtask

    task automatic test_read_latency();
        run_cmd(1'b0, 1'b0, 19'h00010, 4'b0000, '0);
        checks++; if (rdv_cyc - acc_cyc !== RD_LAT) $display("FAIL rd_latency: got %0d required %0d", rdv_cyc - acc_cyc, RD_LAT); else passes++;
        checks++; if (rdv_data !== 32'hDEADBEEF) $display("FAIL rd_data: got %h required DEADBEEF", rdv_data); else passes++;
        checks++; if (oe_cyc !== LANES * (RD_WAIT + 1)) $display("FAIL rd_oe_cycles: got %0d required %0d", oe_cyc, LANES * (RD_WAIT + 1)); else passes++;
        checks++; if (we_cyc !== 0 || rdv_cnt !== 1) $display("FAIL rd_strobes: got we=%0d rdv=%0d required 0 and 1", we_cyc, rdv_cnt); else passes++;
        @(negedge clk);
        checks++;
        if (readdata !== 32'hDEADBEEF || readdatavalid !== 1'b0)
            $display("FAIL rd_hold: got %h/%b required DEADBEEF/0", readdata, readdatavalid);
        else passes++;
    endtask

    task automatic test_partial_write();
        run_cmd(1'b1, 1'b0, 19'h00010, 4'b0100, 32'h12340000);
        checks++; if (sram[20'h21] !== 16'hDE34) $display("FAIL pw_lane1: got %h required DE34", sram[20'h21]); else passes++;
        checks++; if (sram[20'h20] !== 16'hBEEF) $display("FAIL pw_lane0: got %h required BEEF", sram[20'h20]); else passes++;
        checks++;
        if (ce_cyc !== WR_WAIT + 2 || ce_addrs[0] !== 20'h21 || ce_addrs[ce_addrs.size()-1] !== 20'h21)
            $display("FAIL pw_skip: got %0d CE cycles first=%h required %0d at 00021", ce_cyc, ce_addrs[0], WR_WAIT + 2);
        else passes++;
        checks++;
        if (lb_cyc !== WR_WAIT + 1 || ub_cyc !== 0)
            $display("FAIL pw_bytes: got lb=%0d ub=%0d required %0d and 0", lb_cyc, ub_cyc, WR_WAIT + 1);
        else passes++;
    endtask

    task automatic test_zero_be();
        run_cmd(1'b1, 1'b0, 19'h00010, 4'b0000, 32'hFFFFFFFF);
        checks++; if (busy !== 0 || ce_cyc !== 0) $display("FAIL zero_be: got busy=%0d ce=%0d required 0 and 0", busy, ce_cyc); else passes++;
        checks++;
        if ({sram[20'h21], sram[20'h20]} !== 32'hDE34BEEF)
            $display("FAIL zero_be_mem: got %h required DE34BEEF", {sram[20'h21], sram[20'h20]});
        else passes++;
    endtask

    task automatic test_reset_midread();
        int seen = 0;
        @(negedge clk);
        address = 19'h00010; read = 1'b1;
        @(posedge clk); #1 read = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({SRAM_CE_N, SRAM_OE_N} !== 2'b11) $display("FAIL abort_ctrl: got CE/OE=%b required 11", {SRAM_CE_N, SRAM_OE_N});
        else passes++;
        for (int i = 0; i < 10; i++) begin
            if (readdatavalid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) $display("FAIL abort_rdv: got %0d strobes required 0", seen); else passes++;
        checks++; if (readdata !== '0) $display("FAIL abort_readdata: got %h required 0", readdata); else passes++;
        run_cmd(1'b0, 1'b0, 19'h00010, 4'b0000, '0);
        checks++; if (rdv_data !== ref_read(19'h00010)) $display("FAIL abort_reread: got %h required %h", rdv_data, ref_read(19'h00010)); else passes++;
    endtask

    task automatic test_random();
        logic [HAW-1:0]      a;
        logic [2*LANES-1:0]  be;
        logic [16*LANES-1:0] d, e;
        logic                w;
        for (int i = 0; i < 40; i++) begin
            a  = HAW'($urandom_range(0, 63));
            w  = 1'($urandom_range(0, 1));
            be = (2*LANES)'($urandom);
            d  = (16*LANES)'($urandom);
            if (w) begin
                run_cmd(1'b1, 1'b0, a, be, d);
                checks++;
                if (busy !== active_lanes(be) * (WR_WAIT + 2) || we_cyc !== active_lanes(be) * (WR_WAIT + 1))
                    $display("FAIL rand_wr_timing: addr=%h be=%b busy=%0d we=%0d required %0d/%0d", a, be, busy, we_cyc,
                             active_lanes(be) * (WR_WAIT + 2), active_lanes(be) * (WR_WAIT + 1));
                else passes++;
            end else begin
                e = ref_read(a);
                run_cmd(1'b0, 1'b0, a, be, d);
                checks++;
                if (rdv_data !== e || rdv_cyc - acc_cyc !== RD_LAT)
                    $display("FAIL rand_rd: addr=%h got %h lat=%0d required %h lat=%0d", a, rdv_data, rdv_cyc - acc_cyc, e, RD_LAT);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [HAW-1:0]      ca[4];
        logic                ck[4];
        logic [16*LANES-1:0] cd[4];
        logic [16*LANES-1:0] expq[$];
        logic [16*LANES-1:0] e;
        int acc[4];
        int idx = 0, nrdv = 0;
        bit acc_now;
        ca = '{19'h00010, 19'h00005, 19'h00030, 19'h00030};
        ck = '{1'b0, 1'b0, 1'b1, 1'b0};
        cd = '{32'h0, 32'h0, 32'($urandom), 32'h0};
        acc = '{0, 0, 0, 0};
        do_reset();
        expq.push_back(ref_read(ca[0]));
        expq.push_back(ref_read(ca[1]));
        ref_write(ca[2], 4'b1111, cd[2]);
        expq.push_back(ref_read(ca[3]));
        @(posedge clk); #1;
        address = ca[0]; byteenable = 4'b1111; writedata = cd[0]; write = ck[0]; read = 1'b1;
        for (int i = 0; i < 100 && (idx < 4 || nrdv < 3); i++) begin
            @(negedge clk);
            if (readdatavalid) begin
                nrdv++;
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    checks++; if (readdata !== e) $display("FAIL b2b_data%0d: got %h required %h", nrdv, readdata, e); else passes++;
                end
            end
            acc_now = (idx < 4) && !waitrequest;
            if (acc_now) acc[idx] = cyc;
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx < 4) begin
                    address = ca[idx]; writedata = cd[idx]; write = ck[idx]; read = 1'b1;
                end else begin
                    read = 1'b0; write = 1'b0;
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (readdatavalid) nrdv++;
        end
        checks++; if (idx !== 4 || nrdv !== 3) $display("FAIL b2b_counts: got accepts=%0d rdv=%0d required 4 and 3", idx, nrdv); else passes++;
        checks++;
        if (acc[1] - acc[0] !== RD_LAT || acc[2] - acc[1] !== RD_LAT || acc[3] - acc[2] !== LANES * (WR_WAIT + 2) + 1)
            $display("FAIL b2b_spacing: got %0d,%0d,%0d required %0d,%0d,%0d", acc[1] - acc[0], acc[2] - acc[1],
                     acc[3] - acc[2], RD_LAT, RD_LAT, LANES * (WR_WAIT + 2) + 1);
        else passes++;
        checks++;
        if ({sram[word_idx(ca[2], 1)], sram[word_idx(ca[2], 0)]} !== cd[2])
            $display("FAIL b2b_write: got %h required %h", {sram[word_idx(ca[2], 1)], sram[word_idx(ca[2], 0)]}, cd[2]);
        else passes++;
`ifdef SRAM_CTRL_WIDE_STATS_EN
        checks++;
        if (stat_rd_count !== 32'd3 || stat_wr_count !== 32'd1)
            $display("FAIL b2b_stats: got rd=%0d wr=%0d required 3 and 1", stat_rd_count, stat_wr_count);
        else passes++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        test_reset();
        test_write_full();
        test_read_latency();
        test_partial_write();
        test_zero_be();
        test_reset_midread();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
